note_sequencer: RTL and testbench

Upstream feeder for the tone generator. Buffers note events from the game/drum logic in a small FIFO and plays each one for a programmed number of beats, with a fixed silent gap between notes. Drives the 8-bit fullnote code (0 = silence, 1..71 = semitone index) that the tone generator consumes. It replaces the free-running address counter and ROM as the note source.

---
 rtl/music_pkg.sv | 47 ++++
 rtl/note_fifo.sv | 81 ++++++++
 rtl/note_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_note_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// ---------------------------------------------------------------------------
// music_pkg
//   Shared types and constants for the note sequencer and its FIFO.
//
//   NOTE_W / BEATS_W  : widths of the note code and of the beat field as
//                       presented at the input port.
//   DUR_W             : width of the stored beat count. One bit wider than
//                       BEATS_W so that an input of 0 can be kept as 16.
//   MAX_NOTE / REST   : highest playable semitone index and the silence code.
//   seq_state_t       : sequencer FSM state.
//   note_entry_t      : one FIFO entry {note, beats}, already sanitised.
//   sanitize_entry()  : maps a raw input pair onto a storable entry.
// ---------------------------------------------------------------------------
package music_pkg;

    localparam int NOTE_W  = 8;
    localparam int BEATS_W = 4;
    localparam int DUR_W   = BEATS_W + 1;

    localparam logic [NOTE_W-1:0] MAX_NOTE = 8'd71;
    localparam logic [NOTE_W-1:0] REST     = 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  beats;
    } note_entry_t;

    localparam int ENTRY_W = NOTE_W + DUR_W;

    // Out-of-range notes become rests; a beat field of 0 means 16 beats.
    function automatic note_entry_t sanitize_entry(
        input logic [NOTE_W-1:0]  note,
        input logic [BEATS_W-1:0] beats
    );
        note_entry_t e;
        e.note  = (note > MAX_NOTE) ? REST : note;
        e.beats = (beats == '0) ? {1'b1, {BEATS_W{1'b0}}} : {1'b0, beats};
        return e;
    endfunction

endpackage

// File: rtl/note_fifo.sv
// ---------------------------------------------------------------------------
// note_fifo
//   Synchronous show-ahead FIFO with a registered occupancy count.
//
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   clear      : synchronous clear; wins over push and pop on the same edge
//   push/wdata : write request and data; ignored when full or clearing
//   pop        : read request; ignored when empty or clearing
//   rdata      : head entry, valid whenever empty is low
//   full/empty : derived from the count register only
//   count      : number of occupied entries (0..DEPTH)
// ---------------------------------------------------------------------------
module note_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    // Full is judged on the registered count, so a full FIFO refuses a write
    // even if a pop frees a slot on the same edge.
    assign w_do_push = push && !full  && !clear;
    assign w_do_pop  = pop  && !empty && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
//   Queues note events and plays each for a programmed number of beats,
//   followed by a fixed silent gap, driving the fullnote code consumed by
//   the tone generator.
//
//   sysclk     : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : note event offered; accepted on an edge with in_ready high
//   in_ready   : FIFO has room and no flush is in progress (combinational)
//   in_note    : note code (0 = rest, 1..71 semitone, larger stored as rest)
//   in_beats   : duration in beats, 0 means 16
//   flush      : synchronous abort of the queue and the current note
//   fullnote   : registered note code (0 outside PLAY)
//   playing    : registered, high while in PLAY (rests included)
//   fifo_count : registered FIFO occupancy
//   dbg_state  : current FSM state, for observation only
//
//   Handshake: an entry transfers on every rising edge where in_valid and
//   in_ready are both high; in_valid may be raised or dropped at any time
//   and in_ready depends only on the count register and flush.
// ---------------------------------------------------------------------------
module note_sequencer
    import music_pkg::*;
#(
    parameter int BEAT_DIV   = 6_250_000,
    parameter int GAP_CYCLES = 250_000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sysclk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NOTE_W-1:0]             in_note,
    input  logic [BEATS_W-1:0]            in_beats,
    input  logic                          flush,
    output logic [NOTE_W-1:0]             fullnote,
    output logic                          playing,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output seq_state_t                    dbg_state
);

    localparam int PRE_W = $clog2(BEAT_DIV);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BEAT_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    seq_state_t        r_state;
    logic [NOTE_W-1:0] r_fullnote;
    logic              r_playing;
    logic [PRE_W-1:0]  r_presc;       // cycle within the current beat
    logic [DUR_W-1:0]  r_beats_left;  // beats remaining, including current
    logic [GAP_W-1:0]  r_gap;         // cycle within the silent gap

    // ------------------------------------------------------------------
    // FIFO interface
    // ------------------------------------------------------------------
    note_entry_t        w_wr_entry;
    note_entry_t        w_head;
    logic [ENTRY_W-1:0] w_head_bits;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic               w_push;
    logic               w_pop;
    logic               w_play_end;
    logic               w_gap_end;

    assign w_wr_entry = sanitize_entry(in_note, in_beats);
    assign w_head     = note_entry_t'(w_head_bits);

    assign in_ready = !w_full && !flush;
    assign w_push   = in_valid && in_ready;

    // Last cycle of the last beat, and last cycle of the gap.
    assign w_play_end = (r_state == ST_PLAY) && (r_presc == PRE_LAST)
                        && (r_beats_left == DUR_W'(1));
    assign w_gap_end  = (r_state == ST_GAP) && (r_gap == GAP_LAST);

    // The head is taken whenever the FSM is about to start a note: from
    // IDLE, at the end of a gap, or back-to-back when there is no gap.
    assign w_pop = !flush && !w_empty
                   && ((r_state == ST_IDLE) || w_gap_end || (w_play_end && !HAS_GAP));

    note_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (sysclk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wr_entry),
        .rdata (w_head_bits),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM with prescaler, beat and gap counters. Every counter
    // restarts from a known value whenever a state is entered.
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_fullnote   <= REST;
            r_playing    <= 1'b0;
            r_presc      <= '0;
            r_beats_left <= '0;
            r_gap        <= '0;
        end else if (flush) begin
            r_state      <= ST_IDLE;
            r_fullnote   <= REST;
            r_playing    <= 1'b0;
            r_presc      <= '0;
            r_beats_left <= '0;
            r_gap        <= '0;
        end else if (w_pop) begin
            // Start (or restart) PLAY with the head entry.
            r_state      <= ST_PLAY;
            r_fullnote   <= w_head.note;
            r_playing    <= 1'b1;
            r_presc      <= '0;
            r_beats_left <= w_head.beats;
            r_gap        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_fullnote <= REST;
                    r_playing  <= 1'b0;
                end

                ST_PLAY: begin
                    if (w_play_end) begin
                        // Queue empty, or a gap follows every note.
                        r_state      <= HAS_GAP ? ST_GAP : ST_IDLE;
                        r_fullnote   <= REST;
                        r_playing    <= 1'b0;
                        r_presc      <= '0;
                        r_beats_left <= '0;
                        r_gap        <= '0;
                    end else if (r_presc == PRE_LAST) begin
                        r_presc      <= '0;
                        r_beats_left <= r_beats_left - 1'b1;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (w_gap_end) begin
                        // Reached only with an empty queue; otherwise w_pop.
                        r_state <= ST_IDLE;
                        r_gap   <= '0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_fullnote <= REST;
                    r_playing  <= 1'b0;
                end
            endcase
        end
    end

    assign fullnote   = r_fullnote;
    assign playing    = r_playing;
    assign fifo_count = w_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
  import music_pkg::*;

  localparam int BEAT_DIV   = 4;
  localparam int GAP_CYCLES = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 3;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_GAP  = 2;

  logic             sysclk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_note;
  logic [3:0]       in_beats;
  logic             flush;
  logic [7:0]       fullnote;
  logic             playing;
  logic [CNT_W-1:0] fifo_count;
  seq_state_t       dbg_state;

  note_sequencer #(
    .BEAT_DIV   (BEAT_DIV),
    .GAP_CYCLES (GAP_CYCLES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_note    (in_note),
    .in_beats   (in_beats),
    .flush      (flush),
    .fullnote   (fullnote),
    .playing    (playing),
    .fifo_count (fifo_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  // packed expectation: {state[1:0], count[2:0], playing, note[7:0]}
  logic [13:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of pending notes with their total length in cycles; the current
  // phase is tracked as a number of cycles still to run.
  int         m_mode = M_IDLE;
  int         m_left = 0;
  logic [7:0] m_note = 8'd0;
  int         m_q_note[$];
  int         m_q_len[$];

  function automatic logic [13:0] model_outputs();
    logic [7:0] n;
    n = (m_mode == M_PLAY) ? m_note : 8'd0;
    return {2'(m_mode), 3'(m_q_note.size()), (m_mode == M_PLAY), n};
  endfunction

  task automatic model_start();
    m_note = 8'(m_q_note.pop_front());
    m_left = m_q_len.pop_front();
    m_mode = M_PLAY;
  endtask

  task automatic model_step();
    bit accept;
    accept = in_valid && (m_q_note.size() < FIFO_DEPTH) && !flush;
    if (flush) begin
      m_q_note.delete();
      m_q_len.delete();
      m_mode = M_IDLE;
      m_left = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (m_q_note.size() > 0) model_start();
        M_PLAY: begin
          m_left--;
          if (m_left == 0) begin
            if (GAP_CYCLES > 0) begin
              m_mode = M_GAP;
              m_left = GAP_CYCLES;
            end else if (m_q_note.size() > 0) model_start();
            else m_mode = M_IDLE;
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            if (m_q_note.size() > 0) model_start();
            else m_mode = M_IDLE;
          end
        end
      endcase
    end
    if (accept) begin
      m_q_note.push_back((in_note > 71) ? 0 : int'(in_note));
      m_q_len.push_back(((in_beats == 0) ? 16 : int'(in_beats)) * BEAT_DIV);
    end
  endtask

  always @(negedge rst_n) begin
    m_mode = M_IDLE;
    m_left = 0;
    m_note = 8'd0;
    m_q_note.delete();
    m_q_len.delete();
    exp_q.delete();
  end

  always @(posedge sysclk) begin
    if (rst_n) model_step();
    exp_q.push_back(model_outputs());
  end

  // ---------------- monitor ----------------
  always @(negedge sysclk) begin
    logic [13:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("fullnote",   fullnote,        e[7:0]);
      check("playing",    playing,         e[8]);
      check("fifo_count", fifo_count,      e[11:9]);
      check("in_ready",   in_ready,        (e[11:9] < FIFO_DEPTH) && !flush);
      check("state",      int'(dbg_state), e[13:12]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_note  = 8'd0;
    in_beats = 4'd0;
    flush    = 1'b0;
  endtask

  task automatic push(input logic [7:0] n, input logic [3:0] b);
    in_valid = 1'b1;
    in_note  = n;
    in_beats = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (!(dbg_state == ST_IDLE && fifo_count == 0) && k < budget) begin
      tick();
      k++;
    end
    n_tests++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
    end
    repeat (3) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge sysclk);
    #1 rst_n = 1'b1;
    repeat (2) tick();

    // single note into idle block
    push(8'd24, 4'd2);
    wait_idle("single_note", 100);

    // three back-to-back notes, last one a rest
    push(8'd24, 4'd1);
    push(8'd36, 4'd1);
    push(8'd0,  4'd1);
    wait_idle("three_notes", 200);

    // hold in_valid for 6 cycles: FIFO fills, later offers refused
    in_valid = 1'b1;
    in_beats = 4'd1;
    for (int i = 0; i < 6; i++) begin
      in_note = 8'(10 + i);
      tick();
    end
    in_valid = 1'b0;
    wait_idle("fill_fifo", 300);

    // out-of-range note and zero beats -> 16-beat rest
    push(8'd80, 4'd0);
    wait_idle("sanitise", 200);

    // flush mid-note with a concurrent write
    push(8'd50, 4'd3);
    push(8'd60, 4'd2);
    repeat (4) tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_note  = 8'd30;
    in_beats = 4'd2;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", fifo_count, 0);
    check("flush_fullnote", fullnote, 0);
    repeat (6) tick();

    // asynchronous reset between edges, mid-note
    push(8'd40, 4'd4);
    repeat (5) tick();
    check("pre_reset_note", fullnote, 40);
    #2 rst_n = 1'b0;
    #1;
    check("async_fullnote", fullnote, 0);
    check("async_count", fifo_count, 0);
    check("async_playing", playing, 0);
    repeat (2) @(posedge sysclk);
    #1 rst_n = 1'b1;
    repeat (20) tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_note  = 8'($urandom_range(0, 90));
      in_beats = 4'($urandom_range(0, 3));
      flush    = ($urandom_range(0, 149) == 0);
      tick();
    end
    idle_inputs();
    wait_idle("random_drain", 3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 1000000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
